// File: rtl/df_gate_checker.sv
// Clocked stimulus-and-check sequencer for the AND/OR/NOT gate cells: walks a/b through 00..11 and scores each vector.
// Optional GATE_CHK_STOP_ON_FAIL_EN: stop at the first failing vector and freeze a/b there.
module df_gate_checker #(
  parameter int STEP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_and,
  input  logic       y_or,
  input  logic       y_not,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [2:0] mismatch_flags,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(STEP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] err_q, err_d;
  logic [2:0] flags_q, flags_d;
  logic [2:0] fail_bits;

  // a/b always follow the vector index; DONE leaves it at 3 (or the failing vector).
  assign a              = vec_q[1];
  assign b              = vec_q[0];
  assign busy           = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done           = (state_q == DONE);
  assign pass           = done && (err_q == 3'd0);
  assign err_count      = err_q;
  assign mismatch_flags = flags_q;
  assign vec_idx        = vec_q;

  assign fail_bits = {y_not != ~a, y_or != (a | b), y_and != (a & b)};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    flags_d = flags_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          cnt_d   = 8'd0;
          vec_d   = 2'd0;
          err_d   = 3'd0;
          flags_d = 3'd0;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (|fail_bits) begin
          flags_d = flags_q | fail_bits;
          err_d   = err_q + 3'd1;
        end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (|fail_bits || vec_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + 2'd1;
          cnt_d   = 8'd0;
        end
`else
        if (vec_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + 2'd1;
          cnt_d   = 8'd0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      vec_q   <= 2'd0;
      err_q   <= 3'd0;
      flags_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_df_gate_checker.sv
// Bench for df_gate_checker: bench-side gate models with injectable faults, a per-cycle
// expected-trace model derived from vector timing, and literal end-of-run checks.
module tb_df_gate_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sel;
  int   fault;
  logic start0, start1;
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  // Gate cell model; fault 1: OR stuck 0, 2: NOT returns a, 3: AND stuck 1.
  function automatic logic [2:0] gate(input logic ga, input logic gb, input int f);
    logic ya, yo, yn;
    ya = ga & gb; yo = ga | gb; yn = ~ga;
    if (f == 1) yo = 1'b0;
    if (f == 2) yn = ga;
    if (f == 3) ya = 1'b1;
    return {yn, yo, ya};
  endfunction

  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [2:0] err0, flg0, err1, flg1, g0, g1;
  logic [1:0] vec0, vec1;
  assign g0 = gate(a0, b0, fault);
  assign g1 = gate(a1, b1, fault);

  df_gate_checker #(.STEP_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .y_and(g0[0]), .y_or(g0[1]), .y_not(g0[2]),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .mismatch_flags(flg0), .vec_idx(vec0));

  df_gate_checker #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_and(g1[0]), .y_or(g1[1]), .y_not(g1[2]),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .mismatch_flags(flg1), .vec_idx(vec1));

  logic ma, mb, mbusy, mdone, mpass;
  logic [2:0] merr, mflg;
  logic [1:0] mvec;
  assign ma    = sel ? a1 : a0;
  assign mb    = sel ? b1 : b0;
  assign mbusy = sel ? busy1 : busy0;
  assign mdone = sel ? done1 : done0;
  assign mpass = sel ? pass1 : pass0;
  assign merr  = sel ? err1 : err0;
  assign mflg  = sel ? flg1 : flg0;
  assign mvec  = sel ? vec1 : vec0;

  int checks = 0, errors = 0;
  int m_p, m_nend, m_fin, j, first_done;
  logic [2:0] m_fail [4];
  bit track = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, j);
    end
  endtask

  // Expected run: per-vector fail bits, cycle at which done appears, final vector.
  task automatic setup_model(input int s, input int flt);
    int f;
    m_p = s + 1;
    f = -1;
    for (int v = 0; v < 4; v++) begin
      m_fail[v] = gate(v[1], v[0], flt) ^ gate(v[1], v[0], 0);
      if (m_fail[v] != 3'd0 && f < 0) f = v;
    end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    if (f >= 0) begin m_nend = (f + 1) * m_p; m_fin = f; end
    else begin m_nend = 4 * m_p; m_fin = 3; end
`else
    m_nend = 4 * m_p; m_fin = 3;
`endif
  endtask

  // Cycle j counts cycles after the start edge; vector v is sampled at the end of cycle (v+1)*P-1.
  always @(negedge clk) begin
    int jj, v, e;
    logic [2:0] fl;
    if (track) begin
      jj = (j < m_nend) ? j : m_nend;
      v  = (j < m_nend) ? j / m_p : m_fin;
      e  = 0; fl = 3'd0;
      for (int i = 0; i < 4; i++)
        if (m_fail[i] != 3'd0 && (i + 1) * m_p <= jj) begin e++; fl |= m_fail[i]; end
      chk("vec_idx", mvec, v);
      chk("a", ma, (v >> 1) & 1);
      chk("b", mb, v & 1);
      chk("busy", mbusy, (j < m_nend) ? 1 : 0);
      chk("done", mdone, (j >= m_nend) ? 1 : 0);
      chk("err_count", merr, e);
      chk("mismatch_flags", mflg, fl);
      chk("pass", mpass, (j >= m_nend && e == 0) ? 1 : 0);
      if (mdone && first_done < 0) first_done = j;
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, ".a"}, ma, 0);       chk({nm, ".b"}, mb, 0);
    chk({nm, ".busy"}, mbusy, 0); chk({nm, ".done"}, mdone, 0);
    chk({nm, ".pass"}, mpass, 0); chk({nm, ".vec"}, mvec, 0);
    chk({nm, ".err"}, merr, 0);   chk({nm, ".flags"}, mflg, 0);
  endtask

  task automatic run(input bit s1, input int flt, input int inj, input int abort_j);
    sel = s1; fault = flt; first_done = -1;
    setup_model(s1 ? 1 : 2, flt);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0; j = 0; track = 1'b1;
    while (j <= m_nend) begin
      if (j == abort_j) begin
        track = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk_zero("abort");
        return;
      end
      start = (j == inj);
      @(posedge clk); #1 j++;
    end
    start = 1'b0; track = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; fault = 0; j = 0; first_done = -1;
    repeat (2) @(posedge clk);
    #1 chk_zero("rst0");
    sel = 1'b1; #1 chk_zero("rst1");
    rst = 1'b0; sel = 1'b0;

    run(1'b0, 0, -1, -1);
    chk("t1.latency", first_done, 12); chk("t1.pass", mpass, 1);
    chk("t1.err", merr, 0); chk("t1.flags", mflg, 0);

    run(1'b0, 1, -1, -1);
    chk("t2.err", merr, 3); chk("t2.flags", mflg, 2); chk("t2.pass", mpass, 0);

    run(1'b0, 2, -1, -1);
    chk("t3.err", merr, 4); chk("t3.flags", mflg, 4); chk("t3.pass", mpass, 0);

    run(1'b0, 1, -1, 5);
    run(1'b0, 0, -1, -1);
    chk("t4.pass", mpass, 1); chk("t4.err", merr, 0);

    run(1'b1, 0, 2, -1);
    chk("t5.latency", first_done, 8); chk("t5.pass", mpass, 1);
    run(1'b1, 1, -1, -1);
    chk("t5.err_fail", merr, 3);
    run(1'b1, 0, -1, -1);
    chk("t5.err_relaunch", merr, 0); chk("t5.pass_relaunch", mpass, 1);

    run(1'b0, 3, -1, -1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    chk("t6.latency", first_done, 3); chk("t6.vec", mvec, 0);
    chk("t6.err", merr, 1); chk("t6.flags", mflg, 1); chk("t6.pass", mpass, 0);
`else
    chk("t6.latency", first_done, 12); chk("t6.vec", mvec, 3);
    chk("t6.err", merr, 3); chk("t6.flags", mflg, 1); chk("t6.pass", mpass, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
